// File: rtl/handwash_echo_sampler.sv
`default_nettype none
// ============================================================================
// handwash_echo_sampler - alternating L/R ultrasonic echo timer with per-side AGC (rev 1.0)
// ============================================================================
module handwash_echo_sampler #(
  parameter int PERIOD_CYCLES  = 500000,
  parameter int TRIG_CYCLES    = 100,
  parameter int ECHO_TIMEOUT   = 300000,
  parameter int DIST_SHIFT     = 6,
  parameter int GAIN_INIT      = 64,
  parameter int GAIN_STEP      = 8,
  parameter int GAIN_MIN       = 16,
  parameter int GAIN_DOWN_DIST = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        echoLeft,
  input  logic        echoRight,
  output logic        trigLeft,
  output logic        trigRight,
  output logic [7:0]  frontEndGainLeft,
  output logic [7:0]  frontEndGainRight,
  output logic        acceptLeftHandDistance,
  output logic [15:0] leftHandDistance,
  output logic        acceptLeftHandGain,
  output logic [7:0]  leftHandGain,
  output logic        acceptRightHandDistance,
  output logic [15:0] rightHandDistance,
  output logic        acceptRightHandGain,
  output logic [7:0]  rightHandGain
);

  localparam int CNT_MAX = (ECHO_TIMEOUT > TRIG_CYCLES) ? ECHO_TIMEOUT : TRIG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(PERIOD_CYCLES);

  typedef enum logic [2:0] {
    S_INIT, S_TRIG, S_WAIT_RISE, S_MEASURE, S_STUCK, S_REPORT, S_WAIT_PERIOD
  } stateT;

  typedef enum logic [1:0] {R_VALID, R_NO_ECHO, R_STUCK} resultT;

  stateT         state;
  logic          sideRight;
  logic [CW-1:0] count;
  logic [PW-1:0] periodCnt;
  logic [7:0]    gainLeft;
  logic [7:0]    gainRight;
  logic          echoLeftMeta, echoLeftSync;
  logic          echoRightMeta, echoRightSync;

  logic          echoSel;
  logic [7:0]    curGain;
  logic          reportNow;
  resultT        resultKind;
  logic [CW:0]   highClocks;
  logic [31:0]   scaled;
  logic [15:0]   reportDist;
  logic [8:0]    gainUp;
  logic [7:0]    newGain;

  assign echoSel = sideRight ? echoRightSync : echoLeftSync;
  assign curGain = sideRight ? gainRight : gainLeft;

  // The rise cycle is seen in WAIT_RISE, so MEASURE's count is one short of the high time.
  assign highClocks = {1'b0, count} + (CW + 1)'(1);
  assign scaled     = 32'(highClocks) >> DIST_SHIFT;
  assign gainUp     = {1'b0, curGain} + 9'(GAIN_STEP);

  always_comb begin
    reportNow  = 1'b0;
    resultKind = R_STUCK;
    case (state)
      S_WAIT_RISE: begin
        if (!echoSel && count == CW'(ECHO_TIMEOUT - 1)) begin
          reportNow  = 1'b1;
          resultKind = R_NO_ECHO;
        end
      end
      S_MEASURE: begin
        if (!echoSel) begin
          reportNow  = 1'b1;
          resultKind = R_VALID;
        end else if (count == CW'(ECHO_TIMEOUT - 1)) begin
          reportNow  = 1'b1;
          resultKind = R_STUCK;
        end
      end
      S_STUCK: reportNow = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    reportDist = 16'hFFFF;
    if (resultKind == R_VALID)
      reportDist = (scaled > 32'h0000_FFFE) ? 16'hFFFE : scaled[15:0];
  end

  always_comb begin
    newGain = curGain;
    if (resultKind == R_NO_ECHO)
      newGain = (gainUp > 9'd255) ? 8'd255 : gainUp[7:0];
    else if (resultKind == R_VALID && reportDist < 16'(GAIN_DOWN_DIST))
      newGain = (curGain < 8'(GAIN_MIN + GAIN_STEP)) ? 8'(GAIN_MIN) : curGain - 8'(GAIN_STEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                   <= S_INIT;
      sideRight               <= 1'b0;
      count                   <= '0;
      periodCnt               <= '0;
      gainLeft                <= 8'(GAIN_INIT);
      gainRight               <= 8'(GAIN_INIT);
      echoLeftMeta            <= 1'b0;
      echoLeftSync            <= 1'b0;
      echoRightMeta           <= 1'b0;
      echoRightSync           <= 1'b0;
      trigLeft                <= 1'b0;
      trigRight               <= 1'b0;
      acceptLeftHandDistance  <= 1'b0;
      acceptLeftHandGain      <= 1'b0;
      acceptRightHandDistance <= 1'b0;
      acceptRightHandGain     <= 1'b0;
      leftHandDistance        <= 16'hFFFF;
      rightHandDistance       <= 16'hFFFF;
    end else begin
      echoLeftMeta            <= echoLeft;
      echoLeftSync            <= echoLeftMeta;
      echoRightMeta           <= echoRight;
      echoRightSync           <= echoRightMeta;
      acceptLeftHandDistance  <= 1'b0;
      acceptLeftHandGain      <= 1'b0;
      acceptRightHandDistance <= 1'b0;
      acceptRightHandGain     <= 1'b0;
      // Saturates so an overrunning measurement retriggers straight after REPORT.
      if (periodCnt != PW'(PERIOD_CYCLES - 1))
        periodCnt <= periodCnt + PW'(1);

      case (state)
        S_INIT: begin
          acceptLeftHandGain  <= 1'b1;
          acceptRightHandGain <= 1'b1;
          trigLeft            <= 1'b1;
          count               <= '0;
          periodCnt           <= '0;
          state               <= S_TRIG;
        end
        S_TRIG: begin
          if (count == CW'(TRIG_CYCLES - 1)) begin
            trigLeft  <= 1'b0;
            trigRight <= 1'b0;
            count     <= '0;
            state     <= echoSel ? S_STUCK : S_WAIT_RISE;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_WAIT_RISE: begin
          if (echoSel) begin
            count <= '0;
            state <= S_MEASURE;
          end else if (!reportNow) begin
            count <= count + CW'(1);
          end
        end
        S_MEASURE: begin
          if (!reportNow)
            count <= count + CW'(1);
        end
        S_REPORT: begin
          sideRight <= ~sideRight;
          state     <= S_WAIT_PERIOD;
        end
        S_WAIT_PERIOD: begin
          if (periodCnt == PW'(PERIOD_CYCLES - 1)) begin
            if (sideRight)
              trigRight <= 1'b1;
            else
              trigLeft <= 1'b1;
            count     <= '0;
            periodCnt <= '0;
            state     <= S_TRIG;
          end
        end
        default: ;
      endcase

      if (reportNow) begin
        state <= S_REPORT;
        if (sideRight) begin
          acceptRightHandDistance <= 1'b1;
          rightHandDistance       <= reportDist;
          if (newGain != curGain) begin
            gainRight           <= newGain;
            acceptRightHandGain <= 1'b1;
          end
        end else begin
          acceptLeftHandDistance <= 1'b1;
          leftHandDistance       <= reportDist;
          if (newGain != curGain) begin
            gainLeft           <= newGain;
            acceptLeftHandGain <= 1'b1;
          end
        end
      end
    end
  end

  assign frontEndGainLeft  = gainLeft;
  assign leftHandGain      = gainLeft;
  assign frontEndGainRight = gainRight;
  assign rightHandGain     = gainRight;

endmodule
`default_nettype wire
